// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
//   ADDR_W       : address width of PCs and targets
//   INSTR_BYTES  : default fall-through increment for not-taken branches
//   bp_entry_t   : one in-flight branch {pc, pred_taken, pred_addr}
//   bp_update_t  : one predictor training command {pc, taken, target}
//   bp_state_e   : update-handshake state
package bp_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_addr;
  } bp_entry_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } bp_update_t;

  typedef enum logic {
    IDLE     = 1'b0,
    UPD_WAIT = 1'b1
  } bp_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side bundle of the branch resolve controller.
//   DECODE : d_valid, d_pc, d_pred_taken, d_pred_addr (enqueue a branch)
//   EXEC   : x_resolve, x_taken, x_target (resolve the oldest branch)
//   UPDATE : upd_valid/upd_ready handshake with upd_pc, upd_taken, upd_target
//   FRONT  : redirect_valid, redirect_addr, flush, stall
//   STATUS : occupancy, protocol_err
// master = pipeline/predictor side, slave = controller.
interface branch_resolve_ctrl_if #(
  parameter int DEPTH = 4
) ();
  import bp_pkg::*;

  logic                       d_valid;
  logic [ADDR_W-1:0]          d_pc;
  logic                       d_pred_taken;
  logic [ADDR_W-1:0]          d_pred_addr;
  logic                       x_resolve;
  logic                       x_taken;
  logic [ADDR_W-1:0]          x_target;
  logic                       upd_ready;
  logic                       upd_valid;
  logic [ADDR_W-1:0]          upd_pc;
  logic                       upd_taken;
  logic [ADDR_W-1:0]          upd_target;
  logic                       redirect_valid;
  logic [ADDR_W-1:0]          redirect_addr;
  logic                       flush;
  logic                       stall;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic                       protocol_err;

  modport master (
    output d_valid, d_pc, d_pred_taken, d_pred_addr,
    output x_resolve, x_taken, x_target, upd_ready,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  redirect_valid, redirect_addr, flush, stall, occupancy, protocol_err
  );

  modport slave (
    input  d_valid, d_pc, d_pred_taken, d_pred_addr,
    input  x_resolve, x_taken, x_target, upd_ready,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output redirect_valid, redirect_addr, flush, stall, occupancy, protocol_err
  );
endinterface

// File: rtl/branch_resolve_ctrl_fifo.sv
// bp_inflight_fifo: circular buffer of in-flight branches.
//   push/push_data : append at tail
//   pop            : drop head (head is valid whenever !empty)
//   flush          : discard everything; wins over push and pop
//   count/full/empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  bp_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output bp_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed between pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: tracks decoded branches with their fetch prediction,
// checks them against EXEC outcomes, redirects/flushes on mispredict and
// emits one predictor update per resolved branch over a valid/ready link.
//   clk, reset : clock, synchronous active-high reset
//   bus (slave): decode enqueue, exec resolve, update handshake,
//                redirect/flush/stall, occupancy and protocol_err
module branch_resolve_ctrl #(
  parameter int DEPTH       = 4,
  parameter int INSTR_BYTES = 4
) (
  input logic                  clk,
  input logic                  reset,
  branch_resolve_ctrl_if.slave bus
);
  import bp_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  bp_state_e         state, state_n;
  bp_entry_t         head;
  bp_entry_t         push_entry;
  logic [CNT_W-1:0]  count;
  logic              full, empty, waiting;
  logic              accept, mispredict, push;
  logic [ADDR_W-1:0] correct_addr;

  bp_update_t        upd_q;
  logic              upd_valid_q, redirect_q, flush_q, err_q;
  logic [ADDR_W-1:0] raddr_q;

  assign waiting   = (state == UPD_WAIT);
  assign bus.stall = full || waiting;

  // A full queue stalls decode only; the oldest branch may still resolve,
  // and its pop makes room for a same-cycle enqueue.
  assign accept     = bus.x_resolve && !waiting && !empty;
  assign mispredict = (head.pred_taken != bus.x_taken) ||
                      (bus.x_taken && (head.pred_addr != bus.x_target));
  assign correct_addr = bus.x_taken ? bus.x_target
                                    : head.pc + ADDR_W'(INSTR_BYTES);
  assign push = bus.d_valid && (!bus.stall || accept);

  assign push_entry = '{pc: bus.d_pc, pred_taken: bus.d_pred_taken,
                        pred_addr: bus.d_pred_addr};

  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (accept),
    .flush     (accept && mispredict),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A fresh accept reloads the update register, so IDLE only falls into
  // UPD_WAIT when the pending update was refused and nothing replaced it.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (upd_valid_q && !bus.upd_ready && !accept) state_n = UPD_WAIT;
      UPD_WAIT: if (bus.upd_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Output register stage: everything below appears the cycle after accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_q       <= '0;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      raddr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      redirect_q <= accept && mispredict;
      flush_q    <= accept && mispredict;
      if (accept) begin
        upd_valid_q <= 1'b1;
        upd_q       <= '{pc: head.pc, taken: bus.x_taken, target: bus.x_target};
      end else if (upd_valid_q && bus.upd_ready) begin
        upd_valid_q <= 1'b0;
      end
      if (accept && mispredict) raddr_q <= correct_addr;
      if (bus.x_resolve && (empty || waiting)) err_q <= 1'b1;
    end
  end

  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_pc         = upd_q.pc;
  assign bus.upd_taken      = upd_q.taken;
  assign bus.upd_target     = upd_q.target;
  assign bus.redirect_valid = redirect_q;
  assign bus.redirect_addr  = raddr_q;
  assign bus.flush          = flush_q;
  assign bus.occupancy      = count;
  assign bus.protocol_err   = err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed vector table, hand-written
// corner sequences and constrained-random traffic against a queue model.
module tb_branch_resolve_ctrl;
  import bp_pkg::*;

  localparam int   DEPTH = 4;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.DEPTH(DEPTH)) bus ();

  branch_resolve_ctrl #(.DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  bp_entry_t   m_q[$];
  logic        m_uv, m_ut, m_rv, m_err, m_wait;
  logic [31:0] m_upc, m_utgt, m_raddr;

  typedef struct {
    logic dv; logic [31:0] dpc; logic dpt; logic [31:0] dpa;
    logic xr; logic xt; logic [31:0] xtg; logic ur;
    logic e_uv; logic [31:0] e_upc; logic e_rv; logic [31:0] e_raddr;
    int e_occ; logic e_stall;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic dv, input logic [31:0] dpc, input logic dpt,
                       input logic [31:0] dpa, input logic xr, input logic xt,
                       input logic [31:0] xtg, input logic ur);
    bus.d_valid = dv; bus.d_pc = dpc; bus.d_pred_taken = dpt; bus.d_pred_addr = dpa;
    bus.x_resolve = xr; bus.x_taken = xt; bus.x_target = xtg; bus.upd_ready = ur;
  endtask

  task automatic model_step();
    bp_entry_t e;
    logic stall_m, acc, mp;
    if (reset) begin
      m_q.delete();
      m_uv = 0; m_ut = 0; m_rv = 0; m_err = 0; m_wait = 0;
      m_upc = 0; m_utgt = 0; m_raddr = 0;
      return;
    end
    stall_m = (m_q.size() == DEPTH) || m_wait;
    acc     = bus.x_resolve && !m_wait && (m_q.size() != 0);
    mp      = 0;
    if (bus.x_resolve && (m_q.size() == 0 || m_wait)) m_err = 1;
    if (m_wait) begin
      if (bus.upd_ready) begin m_wait = 0; m_uv = 0; end
    end else if (!acc && m_uv) begin
      if (bus.upd_ready) m_uv = 0;
      else m_wait = 1;
    end
    m_rv = 0;
    if (acc) begin
      e = m_q.pop_front();
      m_uv = 1; m_upc = e.pc; m_ut = bus.x_taken; m_utgt = bus.x_target;
      mp = (e.pred_taken != bus.x_taken) || (bus.x_taken && e.pred_addr != bus.x_target);
      if (mp) begin
        m_q.delete();
        m_rv = 1;
        m_raddr = bus.x_taken ? bus.x_target : e.pc + 32'd4;
      end
    end
    if (bus.d_valid && !mp && (!stall_m || acc))
      m_q.push_back('{pc: bus.d_pc, pred_taken: bus.d_pred_taken, pred_addr: bus.d_pred_addr});
  endtask

  task automatic compare_all();
    chk("upd_valid", 32'(bus.upd_valid), 32'(m_uv));
    chk("upd_pc", bus.upd_pc, m_upc);
    chk("upd_taken", 32'(bus.upd_taken), 32'(m_ut));
    chk("upd_target", bus.upd_target, m_utgt);
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    chk("flush", 32'(bus.flush), 32'(m_rv));
    chk("redirect_addr", bus.redirect_addr, m_raddr);
    chk("occupancy", 32'(bus.occupancy), 32'(m_q.size()));
    chk("stall", 32'(bus.stall), 32'((m_q.size() == DEPTH) || m_wait));
    chk("protocol_err", 32'(bus.protocol_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic ur);
    drive(F, 0, F, 0, F, F, 0, ur);
  endtask

  initial begin
    logic        dv, dpt, xr, xt, ur;
    logic [31:0] dpc, dpa, xtg;

    idle(T);
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_redirect_addr", bus.redirect_addr, 32'd0);
    reset = 1'b0;

    // dv dpc dpt dpa | xr xt xtg ur | e_uv e_upc e_rv e_raddr e_occ e_stall
    vecs.push_back('{T, 32'h100, T, 32'h200, F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  1, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, T, 32'h200, T, T, 32'h100, F, 32'h0,  0, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  0, F});
    vecs.push_back('{T, 32'h40,  T, 32'h80,  F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  1, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, T, 32'h40,  T, 32'h44, 0, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  0, F});
    vecs.push_back('{T, 32'h10,  T, 32'h80,  F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  1, F});
    vecs.push_back('{T, 32'h20,  F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  2, F});
    vecs.push_back('{T, 32'h30,  F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  3, F});
    vecs.push_back('{T, 32'h50,  F, 32'h0,   T, T, 32'h90,  T, T, 32'h10,  T, 32'h90, 0, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  0, F});
    vecs.push_back('{T, 32'hA00, F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  1, F});
    vecs.push_back('{T, 32'hA04, F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  2, F});
    vecs.push_back('{T, 32'hA08, F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  3, F});
    vecs.push_back('{T, 32'hA0C, F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  4, T});
    vecs.push_back('{T, 32'hB00, F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  4, T});
    vecs.push_back('{T, 32'hC00, F, 32'h0,   T, F, 32'h0,   T, T, 32'hA00, F, 32'h0,  4, T});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, T, 32'hA04, F, 32'h0,  3, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, T, 32'hA08, F, 32'h0,  2, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, T, 32'hA0C, F, 32'h0,  1, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   T, F, 32'h0,   T, T, 32'hC00, F, 32'h0,  0, F});
    vecs.push_back('{F, 32'h0,   F, 32'h0,   F, F, 32'h0,   T, F, 32'h0,   F, 32'h0,  0, F});

    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].dpc, vecs[i].dpt, vecs[i].dpa,
            vecs[i].xr, vecs[i].xt, vecs[i].xtg, vecs[i].ur);
      cycle();
      chk($sformatf("vec%0d_upd_valid", i), 32'(bus.upd_valid), 32'(vecs[i].e_uv));
      if (vecs[i].e_uv) chk($sformatf("vec%0d_upd_pc", i), bus.upd_pc, vecs[i].e_upc);
      chk($sformatf("vec%0d_redirect", i), 32'(bus.redirect_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d_raddr", i), bus.redirect_addr, vecs[i].e_raddr);
      chk($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
    end

    // Ten push/pop pairs walk the pointers around the ring several times.
    drive(T, 32'h2000, F, 0, F, F, 0, T);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(T, 32'h2004 + 32'(4 * i), F, 0, T, F, 0, T);
      cycle();
      chk("wrap_order", bus.upd_pc, 32'h2000 + 32'(4 * i));
      chk("wrap_occ", 32'(bus.occupancy), 32'd1);
    end
    drive(F, 0, F, 0, T, F, 0, T);
    cycle();
    chk("wrap_last", bus.upd_pc, 32'h2028);
    idle(T);
    cycle();

    // Backpressure on the update link.
    drive(T, 32'h300, T, 32'h400, F, F, 0, T);
    cycle();
    drive(F, 0, F, 0, T, T, 32'h400, F);
    cycle();
    chk("bp_first_valid", 32'(bus.upd_valid), 32'd1);
    chk("bp_first_pc", bus.upd_pc, 32'h300);
    for (int k = 0; k < 3; k++) begin
      idle(F);
      cycle();
      chk("bp_hold_stall", 32'(bus.stall), 32'd1);
      chk("bp_hold_valid", 32'(bus.upd_valid), 32'd1);
      chk("bp_hold_pc", bus.upd_pc, 32'h300);
      chk("bp_hold_target", bus.upd_target, 32'h400);
    end
    idle(T);
    cycle();
    chk("bp_release_valid", 32'(bus.upd_valid), 32'd0);
    chk("bp_release_stall", 32'(bus.stall), 32'd0);

    // Constrained-random traffic: resolves only where the protocol allows.
    for (int n = 0; n < 800; n++) begin
      ur  = ($urandom_range(0, 3) != 0);
      dv  = ($urandom_range(0, 1) == 1);
      dpc = 32'($urandom) & 32'hFFFF_FFFC;
      dpt = ($urandom_range(0, 1) == 1);
      dpa = 32'($urandom_range(0, 3)) << 4;
      xr  = 0; xt = 0; xtg = 0;
      if (m_q.size() != 0 && !m_wait && !(m_uv && !ur) && $urandom_range(0, 9) < 4) begin
        xr  = 1;
        xt  = ($urandom_range(0, 9) < 7) ? m_q[0].pred_taken : ~m_q[0].pred_taken;
        xtg = ($urandom_range(0, 1) == 1) ? m_q[0].pred_addr : 32'($urandom_range(0, 3)) << 4;
      end
      drive(dv, dpc, dpt, dpa, xr, xt, xtg, ur);
      cycle();
    end
    idle(T);
    cycle();
    cycle();

    // Protocol errors, then reset while an update is stuck in UPD_WAIT.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(F, 0, F, 0, T, T, 32'h10, T);
    cycle();
    chk("err_empty_set", 32'(bus.protocol_err), 32'd1);
    chk("err_empty_no_upd", 32'(bus.upd_valid), 32'd0);
    idle(T);
    cycle();
    chk("err_sticky", 32'(bus.protocol_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(T, 32'h500 + 32'(4 * i), F, 0, F, F, 0, T);
      cycle();
    end
    drive(F, 0, F, 0, T, F, 0, F);
    cycle();
    idle(F);
    cycle();
    chk("wait_occ", 32'(bus.occupancy), 32'd2);
    chk("wait_stall", 32'(bus.stall), 32'd1);
    drive(F, 0, F, 0, T, F, 0, F);
    cycle();
    chk("wait_resolve_ignored", 32'(bus.occupancy), 32'd2);
    chk("wait_resolve_pc", bus.upd_pc, 32'h500);
    reset = 1'b1;
    idle(F);
    cycle();
    reset = 1'b0;
    chk("rst2_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst2_upd_pc", bus.upd_pc, 32'd0);
    chk("rst2_upd_target", bus.upd_target, 32'd0);
    chk("rst2_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("rst2_flush", 32'(bus.flush), 32'd0);
    chk("rst2_raddr", bus.redirect_addr, 32'd0);
    chk("rst2_err", 32'(bus.protocol_err), 32'd0);
    chk("rst2_occ", 32'(bus.occupancy), 32'd0);
    chk("rst2_stall", 32'(bus.stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
